// File: rtl/wide_pack_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wide_pack_buffer
// Description : Packs WORDS narrow words into one wide beat through a
//               fill/output ping-pong with ready/valid backpressure and flush.
//               Define WIDE_PACK_BUFFER_MSW_FIRST_EN to place word 0 at the top.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_pack_buffer #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 8,
    localparam int CNT_W = $clog2(WORDS + 1)
) (
    input  logic                    clk_data,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    wr_en_i,
    output logic                    wr_ready_o,
    input  logic                    flush_i,
    output logic [DATA_W*WORDS-1:0] data_o,
    output logic                    data_valid_o,
    input  logic                    data_ready_i,
    output logic [CNT_W-1:0]        data_cnt_o
);

    localparam int c_BEAT_W = DATA_W * WORDS;

    // Position of the k-th accepted word inside the beat.
    function automatic int slot_of(input int k);
`ifdef WIDE_PACK_BUFFER_MSW_FIRST_EN
        return WORDS - 1 - k;
`else
        return k;
`endif
    endfunction

    logic [c_BEAT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic [c_BEAT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                wr_ready_q, wr_ready_d;

    logic                w_accept;
    logic [CNT_W-1:0]    w_cnt_after;
    logic [c_BEAT_W-1:0] w_fill_after;
    logic                w_full_close;
    logic                w_flush_req;
    logic                w_close;
    logic                w_out_free;
    logic                w_load;

    always_comb begin
        w_accept     = wr_en_i & wr_ready_q;
        w_cnt_after  = fill_cnt_q + {{(CNT_W-1){1'b0}}, w_accept};
        w_fill_after = fill_q;
        for (int k = 0; k < WORDS; k++) begin
            if (w_accept && (fill_cnt_q == CNT_W'(k))) begin
                w_fill_after[slot_of(k)*DATA_W +: DATA_W] = data_i;
            end
        end
        w_full_close = (w_cnt_after == CNT_W'(WORDS));
        // A flush counts the word arriving in the same cycle.
        w_flush_req  = (flush_i | flush_pend_q) & (w_cnt_after != '0);
        w_close      = w_full_close | w_flush_req;
        w_out_free   = ~out_valid_q | data_ready_i;
        w_load       = w_close & w_out_free;
    end

    always_comb begin
        fill_d       = w_fill_after;
        fill_cnt_d   = w_cnt_after;
        flush_pend_d = w_flush_req & ~w_full_close;
        out_d        = out_q;
        out_cnt_d    = out_cnt_q;
        out_valid_d  = out_valid_q;
        // Inputs stall while a closed frame is parked in the fill stage.
        wr_ready_d   = ~(w_close & ~w_out_free);

        if (out_valid_q && data_ready_i) begin
            out_valid_d = 1'b0;
            out_cnt_d   = '0;
        end

        if (w_load) begin
            out_d        = w_fill_after;
            out_cnt_d    = w_cnt_after;
            out_valid_d  = 1'b1;
            fill_d       = '0;
            fill_cnt_d   = '0;
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_data or posedge rst) begin
        if (rst) begin
            fill_q       <= '0;
            fill_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            out_q        <= '0;
            out_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            wr_ready_q   <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            fill_cnt_q   <= fill_cnt_d;
            flush_pend_q <= flush_pend_d;
            out_q        <= out_d;
            out_cnt_q    <= out_cnt_d;
            out_valid_q  <= out_valid_d;
            wr_ready_q   <= wr_ready_d;
        end
    end

    assign wr_ready_o   = wr_ready_q;
    assign data_o       = out_q;
    assign data_valid_o = out_valid_q;
    assign data_cnt_o   = out_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_pack_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_pack_buffer
// Description : Directed and random checks of wide_pack_buffer against a
//               frame-level queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_pack_buffer;

    localparam int DATA_W = 32;
    localparam int WORDS  = 8;
    localparam int CNT_W  = $clog2(WORDS + 1);
    localparam int BEAT_W = DATA_W * WORDS;

    logic              clk_data = 1'b0;
    logic              rst      = 1'b1;
    logic [DATA_W-1:0] data_i   = '0;
    logic              wr_en_i  = 1'b0;
    logic              wr_ready_o;
    logic              flush_i  = 1'b0;
    logic [BEAT_W-1:0] data_o;
    logic              data_valid_o;
    logic              data_ready_i = 1'b0;
    logic [CNT_W-1:0]  data_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;

    // Model: words of the open frame, and closed beats awaiting transfer.
    logic [DATA_W-1:0] frame[$];
    logic [BEAT_W-1:0] exp_d[$];
    int                exp_c[$];

    logic [BEAT_W-1:0] held_d;
    logic [CNT_W-1:0]  held_c;
    logic              held_v = 1'b0;

    always #5 clk_data = ~clk_data;

    wide_pack_buffer #(.DATA_W(DATA_W), .WORDS(WORDS)) dut (
        .clk_data     (clk_data),
        .rst          (rst),
        .data_i       (data_i),
        .wr_en_i      (wr_en_i),
        .wr_ready_o   (wr_ready_o),
        .flush_i      (flush_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .data_cnt_o   (data_cnt_o)
    );

    task automatic chk(input string tag, input logic [BEAT_W-1:0] got,
                       input logic [BEAT_W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] pack(input logic [DATA_W-1:0] w[$]);
        logic [BEAT_W-1:0] b = '0;
        for (int i = 0; i < w.size(); i++) begin
`ifdef WIDE_PACK_BUFFER_MSW_FIRST_EN
            b[(WORDS-1-i)*DATA_W +: DATA_W] = w[i];
`else
            b[i*DATA_W +: DATA_W] = w[i];
`endif
        end
        return b;
    endfunction

    function automatic logic [BEAT_W-1:0] pack_seq(input int first);
        logic [DATA_W-1:0] w[$];
        for (int i = 0; i < WORDS; i++) w.push_back(DATA_W'(first + i));
        return pack(w);
    endfunction

    task automatic model_cycle(input logic acc, input logic [DATA_W-1:0] d,
                               input logic fl);
        if (acc) frame.push_back(d);
        if (frame.size() == WORDS || (fl && frame.size() > 0)) begin
            exp_d.push_back(pack(frame));
            exp_c.push_back(frame.size());
            frame.delete();
        end
    endtask

    // Drive one cycle just after a rising edge; return whether it was accepted.
    task automatic step(input logic en, input logic [DATA_W-1:0] d,
                        input logic fl, output logic acc);
        wr_en_i = en;
        data_i  = d;
        flush_i = fl;
        @(negedge clk_data);
        acc = en & wr_ready_o;
        model_cycle(acc, d, fl);
        @(posedge clk_data);
        #1;
        wr_en_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
    endtask

    task automatic offer(input logic [DATA_W-1:0] d);
        logic a = 1'b0;
        for (int t = 0; t < 100 && !a; t++) step(1'b1, d, 1'b0, a);
        chk("offer_timeout", a, 1);
    endtask

    // Transfer monitor and hold-stability check, sampled mid-cycle.
    always @(negedge clk_data) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_data", data_o, held_d);
                chk("stall_cnt", data_cnt_o, held_c);
            end
            if (data_valid_o && data_ready_i) begin
                n_beats++;
                chk("beat_expected", exp_d.size() > 0, 1);
                if (exp_d.size() > 0) begin
                    chk("beat_data", data_o, exp_d.pop_front());
                    chk("beat_cnt", data_cnt_o, exp_c.pop_front());
                end
            end
            held_v = data_valid_o & ~data_ready_i;
            held_d = data_o;
            held_c = data_cnt_o;
        end
    end

    initial begin
        logic a;
        int   snap;
        logic [DATA_W-1:0] w[$];

        #100;
        chk("rst_data", data_o, 0);
        chk("rst_valid", data_valid_o, 0);
        chk("rst_cnt", data_cnt_o, 0);
        chk("rst_ready", wr_ready_o, 0);
        @(posedge clk_data); #1;
        rst = 1'b0;
        chk("ready_before_edge", wr_ready_o, 0);
        @(posedge clk_data); #1;
        chk("ready_after_rst", wr_ready_o, 1);

        // Streaming at full rate
        data_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, DATA_W'((i < 8) ? 10 + i : 12 + i), 1'b0, a);
            chk("stream_accept", a, 1);
            if (i == 7 || i == 15) begin
                chk("stream_valid", data_valid_o, 1);
                chk("stream_cnt", data_cnt_o, WORDS);
                chk("stream_data", data_o, pack_seq(i == 7 ? 10 : 20));
            end
        end
        idle(2);

        // Backpressure
        data_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, DATA_W'(i), 1'b0, a);
            chk("bp_accept", a, 1);
        end
        chk("bp_ready_low", wr_ready_o, 0);
        chk("bp_out_data", data_o, pack_seq(0));
        idle(3);
        chk("bp_ready_held", wr_ready_o, 0);
        data_ready_i = 1'b1;
        for (int i = 16; i < 24; i++) offer(DATA_W'(i));
        idle(3);
        chk("bp_ready_recover", wr_ready_o, 1);

        // Partial flush
        for (int i = 30; i < 33; i++) offer(DATA_W'(i));
        step(1'b0, '0, 1'b1, a);
        chk("pf_valid", data_valid_o, 1);
        chk("pf_cnt", data_cnt_o, 3);
        w = '{32'd30, 32'd31, 32'd32};
        chk("pf_data", data_o, pack(w));
        idle(2);

        // Flush on empty frame emits nothing
        snap = n_beats;
        step(1'b0, '0, 1'b1, a);
        chk("ef_valid", data_valid_o, 0);
        idle(2);
        chk("ef_beats", n_beats, snap);

        // Flush together with a single word
        step(1'b1, 32'd40, 1'b1, a);
        chk("fw_valid", data_valid_o, 1);
        chk("fw_cnt", data_cnt_o, 1);
        idle(2);

        // Flush while output blocked
        data_ready_i = 1'b0;
        step(1'b1, 32'd60, 1'b1, a);
        step(1'b1, 32'd61, 1'b0, a);
        step(1'b1, 32'd62, 1'b1, a);
        chk("fb_ready_low", wr_ready_o, 0);
        idle(3);
        chk("fb_ready_held", wr_ready_o, 0);
        data_ready_i = 1'b1;
        idle(1);
        chk("fb_ready_recover", wr_ready_o, 1);
        chk("fb_cnt", data_cnt_o, 2);
        idle(2);

        // Reset mid-frame
        for (int i = 1; i <= 5; i++) offer(DATA_W'(i));
        rst = 1'b1;
        frame.delete(); exp_d.delete(); exp_c.delete();
        #1;
        chk("mr_valid", data_valid_o, 0);
        chk("mr_ready", wr_ready_o, 0);
        @(posedge clk_data); @(posedge clk_data); #1;
        rst = 1'b0;
        @(posedge clk_data); #1;
        snap = n_beats;
        for (int i = 50; i < 58; i++) offer(DATA_W'(i));
        chk("mr_valid_beat", data_valid_o, 1);
        chk("mr_data", data_o, pack_seq(50));
        idle(3);
        chk("mr_beats", n_beats, snap + 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            data_ready_i = ($urandom_range(0, 3) != 0);
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 11) == 0), a);
        end
        data_ready_i = 1'b1;
        step(1'b0, '0, 1'b1, a);
        for (int t = 0; t < 50 && (exp_d.size() > 0 || data_valid_o); t++) idle(1);
        chk("drain_queue", exp_d.size(), 0);
        chk("drain_valid", data_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wide_pack_buffer.md
# wide_pack_buffer

Parametrised word-packing buffer that gathers `WORDS` input words of `DATA_W` bits into one wide beat. It sits between the narrow `clk_data`-domain producer and the wide-datapath consumer of the MulAdd accelerator. Frames are ping-ponged through a fill stage and an output stage, so a new frame can be collected while the previous one waits. Output uses a ready/valid handshake with backpressure to the input, and `flush_i` emits partial frames.

## Interface
- `DATA_W`, 32, input word width (≥1)
- `WORDS`, 8, words per output beat (≥2); `CNT_W = $clog2(WORDS+1)` is derived locally
- `clk_data`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `data_i`  in  DATA_W  input word
- `wr_en_i`  in  1  input valid
- `wr_ready_o`  out  1  input ready (registered); word accepted when `wr_en_i & wr_ready_o`
- `flush_i`  in  1  single-cycle request to emit the current partial frame
- `data_o`  out  DATA_W*WORDS  packed output beat
- `data_valid_o`  out  1  output valid
- `data_ready_i`  in  1  consumer ready; beat transferred when `data_valid_o & data_ready_i`
- `data_cnt_o`  out  CNT_W  valid words in `data_o` (`WORDS` for full frames)

## Operation
- State: fill register (`WORDS` slots), `fill_cnt` (0..`WORDS`), `flush_pend`, output register plus `out_valid` and `out_cnt`.
- An accepted word goes to slot `fill_cnt`, then `fill_cnt` increments. Slot k occupies `data_o[k*DATA_W +: DATA_W]`. Unwritten slots are zero.
- Frame closes on either event:
  - (a) The `WORDS`-th word is accepted.
  - (b) `flush_i`, or a pending flush, with ≥1 word in the frame, counting a word accepted in the same cycle.
- Output free = `!out_valid | data_ready_i`.
- Closed frame with output free: at that same edge, the frame, including the word arriving that cycle, loads into the output register. `out_cnt` gets the word count, `fill_cnt` goes to 0 and the fill slots clear.
- Closed frame with output not free: the frame stays in the fill stage. `wr_ready_o` goes low. The transfer happens at the first edge where output is free.
- `flush_i` when frame empty and no word accepted that cycle: ignored, and nothing is emitted.
- `flush_i` while a full frame already waits in fill: ignored.
- A flush that cannot complete immediately sets `flush_pend`. `wr_ready_o` stays low until the partial frame moves to output.
- Output draining (`valid & ready`) with no new frame loading: `out_valid` and `data_cnt_o` clear.
- Beats leave in acceptance order. No word is dropped or duplicated.

## Timing
- Reset values while `rst` is high: `data_o`=0, `data_valid_o`=0, `data_cnt_o`=0, `wr_ready_o`=0, `fill_cnt`=0, `flush_pend`=0.
- `wr_ready_o` rises at the first `clk_data` edge after `rst` deasserts.
- Latency: `data_valid_o` is high in the cycle after the edge that accepts the closing word or flush, when the output is free.
- Full throughput: with `data_ready_i` held high, one word is accepted every cycle with no bubbles. One beat is produced per `WORDS` cycles.
- `wr_ready_o` is registered:
  - It falls in the cycle after a frame closes while the output is blocked.
  - It rises in the cycle after that frame transfers.
  - There is no combinational path from `data_ready_i` or `flush_i` to `wr_ready_o`.
- `data_o` and `data_cnt_o` are stable while `data_valid_o & !data_ready_i`.
- Reset asserted mid-frame or mid-handshake: all state is discarded immediately (asynchronous). The next accepted word is slot 0.

## Configuration
- `WIDE_PACK_BUFFER_MSW_FIRST_EN` undefined: the first word of a frame sits in the least-significant slot. Partial frames are zero-padded at the top.
- `WIDE_PACK_BUFFER_MSW_FIRST_EN` defined: word k maps to slot `WORDS-1-k`, so the first word is at the top of `data_o`. Partial frames are zero-padded at the bottom. Handshake and counts are unchanged.

## Test plan
- Reset: hold `rst`=1 for 100 ns and check all outputs are 0. Release and check `wr_ready_o`=1 on the next edge.
- Streaming: `data_ready_i`=1, 16 back-to-back words 10..17 then 20..27. Expect beats {17..10} then {27..20}, word i at bits [32i+:32], `data_cnt_o`=8. `data_valid_o` must be high in the cycle after words 17 and 27, with `wr_ready_o` never low.
- Backpressure: `data_ready_i`=0, offer 24 words 0..23.
  - `wr_ready_o` drops after word 15, with beat 0..7 in output and 8..15 in fill.
  - Raise ready: beats 0..7, 8..15, 16..23 emerge in order, and `wr_ready_o` recovers.
- Partial flush: words 30,31,32 followed by `flush_i`. Expect `data_cnt_o`=3, `data_o[95:0]`={32,31,30}, upper bits 0.
- Flush edge cases:
  - `flush_i` on an empty frame: no beat.
  - `flush_i` in the same cycle as word 40 on an empty frame: beat with `data_cnt_o`=1 holding 40.
  - Flush while output is blocked: `wr_ready_o` low until drain.
- Reset mid-frame: accept 5 words, pulse `rst`, then stream 50..57. Expect a single beat {57..50} and no residue from before reset. Repeat with `WIDE_PACK_BUFFER_MSW_FIRST_EN` defined and expect 50 at the top slot.
